vco_cal_ctrl: RTL and testbench

VCO_CAL_CTRL -- requirements
Module: vco_cal_ctrl

---
 rtl/vco_cal_pkg.sv | 26 ++
 rtl/vco_cal_ctrl_if.sv | 37 +++
 rtl/vco_edge_counter.sv | 58 +++++
 rtl/vco_cal_ctrl.sv | 179 +++++++++++++++++
 tb/tb_vco_cal_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/vco_cal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vco_cal_pkg
//  Description : Shared types and default constants for the VCO calibration
//                controller: FSM state encoding plus default code width,
//                counter width, settle/window lengths and lock tolerance.
//  Revision    : 1.0  initial release
// ============================================================================
package vco_cal_pkg;

   localparam int c_CODE_W_DEF     = 8;
   localparam int c_CNT_W_DEF      = 16;
   localparam int c_SETTLE_CYC_DEF = 64;
   localparam int c_WIN_CYC_DEF    = 1024;
   localparam int c_TOL_DEF        = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_MEASURE = 3'd2,
      ST_DECIDE  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage : vco_cal_pkg
`default_nettype wire

// File: rtl/vco_cal_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : vco_cal_ctrl_if
//  Description : Control/status bundle of the VCO calibration controller.
//                master : requester side (drives start, abort, target_cnt)
//                slave  : controller side (drives code, busy, done, locked,
//                         meas_cnt)
//  Revision    : 1.0  initial release
// ============================================================================
interface vco_cal_ctrl_if
   import vco_cal_pkg::*;
#(
   parameter int CODE_W = c_CODE_W_DEF,
   parameter int CNT_W  = c_CNT_W_DEF
);

   logic              start;
   logic              abort;
   logic [CNT_W-1:0]  target_cnt;
   logic [CODE_W-1:0] code;
   logic              busy;
   logic              done;
   logic              locked;
   logic [CNT_W-1:0]  meas_cnt;

   modport master (
      output start, abort, target_cnt,
      input  code, busy, done, locked, meas_cnt
   );

   modport slave (
      input  start, abort, target_cnt,
      output code, busy, done, locked, meas_cnt
   );

endinterface : vco_cal_ctrl_if
`default_nettype wire

// File: rtl/vco_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vco_edge_counter
//  Description : Brings the asynchronous divided VCO clock into the clk
//                domain through a 2-flop synchronizer, detects rising edges
//                and counts them with a saturating counter.
//  Ports       : clk     - system clock
//                rst     - asynchronous active-high reset
//                clr     - synchronous clear of the counter (wins over en)
//                en      - count enable
//                vco_div - divided VCO output, asynchronous to clk
//                cnt     - current edge count
//  Revision    : 1.0  initial release
// ============================================================================
module vco_edge_counter
   import vco_cal_pkg::*;
#(
   parameter int CNT_W = c_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             vco_div,
   output logic [CNT_W-1:0] cnt
);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_sync3;
   logic [CNT_W-1:0] r_cnt;
   logic             w_rise;

   // r_sync1/r_sync2 form the synchronizer; r_sync3 is only the edge-detect delay
   assign w_rise = r_sync2 & ~r_sync3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= vco_div;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         if (clr) begin
            r_cnt <= '0;
         end else if (en && w_rise && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign cnt = r_cnt;

endmodule : vco_edge_counter
`default_nettype wire

// File: rtl/vco_cal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vco_cal_ctrl
//  Description : Successive-approximation VCO calibration. Each pass drives
//                a trial code, waits SETTLE_CYC cycles, counts vco_div edges
//                over WIN_CYC cycles and keeps or clears the trial bit by
//                comparing against the target. After the LSB a final verify
//                pass measures the chosen code and reports lock.
//  Ports       : clk     - system clock
//                rst     - asynchronous active-high reset
//                vco_div - divided VCO output, asynchronous to clk
//                bus     - slave side: start/abort/target_cnt in,
//                          code/busy/done/locked/meas_cnt out
//  Revision    : 1.0  initial release
// ============================================================================
module vco_cal_ctrl
   import vco_cal_pkg::*;
#(
   parameter int CODE_W     = c_CODE_W_DEF,
   parameter int CNT_W      = c_CNT_W_DEF,
   parameter int SETTLE_CYC = c_SETTLE_CYC_DEF,
   parameter int WIN_CYC    = c_WIN_CYC_DEF,
   parameter int TOL        = c_TOL_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           vco_div,
   vco_cal_ctrl_if.slave  bus
);

   localparam int c_BIT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam int c_TMR_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
   localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

   localparam logic [CODE_W-1:0]  c_CODE_MSB = {1'b1, {(CODE_W-1){1'b0}}};
   localparam logic [c_TMR_W-1:0] c_SETTLE_LD = c_TMR_W'(SETTLE_CYC - 1);
   localparam logic [c_TMR_W-1:0] c_WIN_LD    = c_TMR_W'(WIN_CYC - 1);
   localparam logic [CNT_W:0]     c_TOL_CMP   = (CNT_W+1)'(TOL);

   state_t              r_state;
   logic [CODE_W-1:0]   r_code;
   logic [c_BIT_W-1:0]  r_bit;
   logic                r_verify;
   logic [c_TMR_W-1:0]  r_tmr;
   logic [CNT_W-1:0]    r_target;
   logic [CNT_W-1:0]    r_meas;
   logic                r_busy;
   logic                r_done;
   logic                r_locked;

   logic                w_clr;
   logic                w_en;
   logic [CNT_W-1:0]    w_cnt;
   logic [CODE_W-1:0]   w_code_dec;
   logic [CNT_W:0]      w_diff;
   logic                w_within;

   // Counter is cleared on the edge that enters MEASURE and only counts there
   assign w_clr = (r_state == ST_SETTLE) && (r_tmr == '0);
   assign w_en  = (r_state == ST_MEASURE);

   vco_edge_counter #(
      .CNT_W   (CNT_W)
   ) u_edge_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_clr),
      .en      (w_en),
      .vco_div (vco_div),
      .cnt     (w_cnt)
   );

   // Search step: too fast -> drop the trial bit, then try the next lower bit
   always_comb begin
      w_code_dec = r_code;
      if (w_cnt > r_target) begin
         w_code_dec[r_bit] = 1'b0;
      end
      if (r_bit != '0) begin
         w_code_dec[r_bit - c_BIT_W'(1)] = 1'b1;
      end
   end

   // Absolute difference needs one extra bit so it can never wrap
   always_comb begin
      w_diff = '0;
      if (w_cnt >= r_target) begin
         w_diff = {1'b0, w_cnt} - {1'b0, r_target};
      end else begin
         w_diff = {1'b0, r_target} - {1'b0, w_cnt};
      end
      w_within = (w_diff <= c_TOL_CMP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_code   <= '0;
         r_bit    <= '0;
         r_verify <= 1'b0;
         r_tmr    <= '0;
         r_target <= '0;
         r_meas   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.abort && (r_state != ST_IDLE)) begin
            // Abort outranks every transition; code is left where it is
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.start && !bus.abort) begin
                     r_state  <= ST_SETTLE;
                     r_code   <= c_CODE_MSB;
                     r_bit    <= c_BIT_W'(CODE_W - 1);
                     r_verify <= 1'b0;
                     r_target <= bus.target_cnt;
                     r_busy   <= 1'b1;
                     r_locked <= 1'b0;
                     r_tmr    <= c_SETTLE_LD;
                  end
               end
               ST_SETTLE: begin
                  if (r_tmr == '0) begin
                     r_state <= ST_MEASURE;
                     r_tmr   <= c_WIN_LD;
                  end else begin
                     r_tmr <= r_tmr - c_TMR_W'(1);
                  end
               end
               ST_MEASURE: begin
                  if (r_tmr == '0) begin
                     r_state <= ST_DECIDE;
                  end else begin
                     r_tmr <= r_tmr - c_TMR_W'(1);
                  end
               end
               ST_DECIDE: begin
                  r_meas <= w_cnt;
                  if (r_verify) begin
                     r_locked <= w_within;
                     r_state  <= ST_DONE;
                  end else begin
                     r_code  <= w_code_dec;
                     r_tmr   <= c_SETTLE_LD;
                     r_state <= ST_SETTLE;
                     if (r_bit == '0) begin
                        r_verify <= 1'b1;
                     end else begin
                        r_bit <= r_bit - c_BIT_W'(1);
                     end
                  end
               end
               ST_DONE: begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.code     = r_code;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.locked   = r_locked;
   assign bus.meas_cnt = r_meas;

endmodule : vco_cal_ctrl
`default_nettype wire

// File: tb/tb_vco_cal_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vco_cal_ctrl
//  Description : Scoreboard bench for vco_cal_ctrl. A VCO model produces
//                exactly 4*code vco_div edges in any WIN_CYC-cycle span;
//                expected results come from a plain SAR reference search.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vco_cal_ctrl;
   import vco_cal_pkg::*;

   localparam int CODE_W     = 8;
   localparam int CNT_W      = 16;
   localparam int SETTLE_CYC = 6;
   localparam int WIN_CYC    = 2040;
   localparam int TOL        = 2;
   localparam int PASS_CYC   = SETTLE_CYC + WIN_CYC + 1;
   localparam int LAT        = 9 * PASS_CYC + 1;

   typedef struct {
      int     code;
      int     meas;
      bit     lk;
      longint s;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   vco_div = 1'b0;
   longint cyc = 0;
   int     vmode = 0;       // 0: model, 1: stuck high, 2: stuck low
   int     acc = 0;
   int     errors = 0;
   int     checks = 0;
   exp_t   sb[$];
   exp_t   mon_e;
   int     tgt;

   vco_cal_ctrl_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) bus ();

   vco_cal_ctrl #(
      .CODE_W     (CODE_W),
      .CNT_W      (CNT_W),
      .SETTLE_CYC (SETTLE_CYC),
      .WIN_CYC    (WIN_CYC),
      .TOL        (TOL)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .vco_div (vco_div),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bresenham pulse train: exactly 4*code one-cycle pulses per WIN_CYC cycles
   initial forever begin
      @(negedge clk);
      if (vmode == 0) begin
         acc = acc + 4 * int'(bus.code);
         if (acc >= WIN_CYC) begin
            acc = acc - WIN_CYC;
            vco_div = 1'b1;
         end else begin
            vco_div = 1'b0;
         end
      end else begin
         vco_div = (vmode == 1);
      end
   end

   // Reference SAR: decide the top ndec bits; a code is kept when its count <= target
   function automatic int ref_code(input int t, input bit stuck, input int ndec);
      int c = 0;
      for (int b = CODE_W - 1; b >= CODE_W - ndec; b--) begin
         int trial = c | (1 << b);
         int m = stuck ? 0 : 4 * trial;
         if (m <= t) c = trial;
      end
      return c;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic issue_start(input int t, input bit expect_done, input bit stuck);
      exp_t e;
      bus.target_cnt = CNT_W'(t);
      bus.start = 1'b1;
      if (expect_done) begin
         e.code = ref_code(t, stuck, CODE_W);
         e.meas = stuck ? 0 : 4 * e.code;
         e.lk   = ((e.meas > t) ? (e.meas - t) : (t - e.meas)) <= TOL;
         e.s    = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // Monitor: every done pulse must match the oldest expected result
   initial forever begin
      @(negedge clk);
      if (!rst && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected 0");
         end else begin
            mon_e = sb.pop_front();
            chk("code",     bus.code,     mon_e.code);
            chk("locked",   bus.locked,   mon_e.lk);
            chk("meas_cnt", bus.meas_cnt, mon_e.meas);
            chk("latency",  cyc - mon_e.s, LAT);
         end
      end
   end

   initial begin
      #(150000 * 10);
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.target_cnt = '0;
      repeat (3) @(negedge clk);
      chk("rst_code",   bus.code,     0);
      chk("rst_busy",   bus.busy,     0);
      chk("rst_done",   bus.done,     0);
      chk("rst_locked", bus.locked,   0);
      chk("rst_meas",   bus.meas_cnt, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Nominal target, plus a start pulse and target change while busy
      issue_start(400, 1'b1, 1'b0);
      chk("busy_after_start", bus.busy, 1);
      repeat ($urandom_range(50, 5000)) @(negedge clk);
      bus.target_cnt = CNT_W'($urandom_range(0, 1200));
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_drain(LAT + 100);

      // start and abort together in IDLE: start is dropped
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("start_abort_idle", bus.busy, 0);

      // Abort during the third MEASURE window
      tgt = $urandom_range(0, 1100);
      issue_start(tgt, 1'b0, 1'b0);
      repeat (2 * PASS_CYC + SETTLE_CYC + $urandom_range(0, WIN_CYC - 1)) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_busy",   bus.busy,   0);
      chk("abort_locked", bus.locked, 0);
      chk("abort_code",   bus.code,   ref_code(tgt, 1'b0, 2) | (1 << (CODE_W - 3)));
      repeat (20) @(negedge clk);
      chk("abort_stays_idle", bus.busy, 0);

      // Recalibrate after abort, then the upper extreme
      issue_start(0, 1'b1, 1'b0);
      wait_drain(LAT + 100);
      issue_start(1100, 1'b1, 1'b0);
      wait_drain(LAT + 100);

      // Asynchronous reset during SETTLE
      vmode = 1;
      repeat (5) @(negedge clk);
      issue_start($urandom_range(0, 1100), 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_code",   bus.code,     0);
      chk("arst_busy",   bus.busy,     0);
      chk("arst_done",   bus.done,     0);
      chk("arst_locked", bus.locked,   0);
      chk("arst_meas",   bus.meas_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Stuck vco_div: high for the first passes, then low
      issue_start($urandom_range(0, 5), 1'b1, 1'b1);
      repeat (4 * PASS_CYC) @(negedge clk);
      vmode = 2;
      wait_drain(LAT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_vco_cal_ctrl
`default_nettype wire
